// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - fetch/execute sequencer driving the PC load/increment strobes
// Handles branch, halt, interrupt entry and return-from-interrupt on each completed instruction.
module pc_sequencer #(
  parameter int ADDR_W = 15,
  parameter logic [ADDR_W-1:0] RESET_VEC = 15'h0000,
  parameter logic [ADDR_W-1:0] IRQ_VEC = 15'h7F00
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] pc_q,
  output logic [ADDR_W-1:0] pc_d,
  output logic              pc_re,
  output logic              pc_inc,
  output logic              imem_req,
  input  logic              imem_ack,
  output logic              ir_load,
  input  logic              done,
  input  logic              br_taken,
  input  logic [ADDR_W-1:0] br_target,
  input  logic              halt,
  input  logic              ret,
  input  logic              irq,
  output logic              irq_ack,
  output logic [2:0]        state
);

  typedef enum logic [2:0] {
    BOOT   = 3'd0,
    FETCH  = 3'd1,
    EXEC   = 3'd2,
    HALTED = 3'd3
  } state_t;

  state_t            st;
  logic [ADDR_W-1:0] epc;
  logic              irq_en;
  logic              irq_pend;
  logic [ADDR_W-1:0] next_pc;
  logic              irq_take;

  assign next_pc  = br_taken ? br_target : pc_q + ADDR_W'(1);
  assign irq_take = irq_pend && irq_en;
  assign state    = st;

  // Strobes are gated by rst so a reset cycle aborts whatever is in flight.
  always_comb begin
    pc_d     = '0;
    pc_re    = 1'b0;
    pc_inc   = 1'b0;
    imem_req = 1'b0;
    ir_load  = 1'b0;
    irq_ack  = 1'b0;
    if (!rst) begin
      case (st)
        BOOT: begin
          pc_d  = RESET_VEC;
          pc_re = 1'b1;
        end
        FETCH: begin
          imem_req = 1'b1;
          ir_load  = imem_ack;
        end
        EXEC: begin
          if (done) begin
            if (ret) begin
              pc_d  = epc;
              pc_re = 1'b1;
            end else if (irq_take) begin
              pc_d    = IRQ_VEC;
              pc_re   = 1'b1;
              irq_ack = 1'b1;
            end else if (br_taken) begin
              pc_d  = br_target;
              pc_re = 1'b1;
            end else begin
              pc_inc = 1'b1;
            end
          end
        end
        HALTED: begin
          if (irq_take) begin
            pc_d    = IRQ_VEC;
            pc_re   = 1'b1;
            irq_ack = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      st       <= BOOT;
      epc      <= '0;
      irq_en   <= 1'b1;
      irq_pend <= 1'b0;
    end else begin
      if (irq_ack) irq_pend <= 1'b0;
      else if (irq && irq_en) irq_pend <= 1'b1;

      case (st)
        BOOT: st <= FETCH;
        FETCH: if (imem_ack) st <= EXEC;
        EXEC: begin
          if (done) begin
            if (ret) begin
              irq_en <= 1'b1;
              st     <= FETCH;
            end else if (irq_take) begin
              // Interrupt entry swallows a same-cycle halt; epc resumes after this instruction.
              epc    <= next_pc;
              irq_en <= 1'b0;
              st     <= FETCH;
            end else begin
              st <= halt ? HALTED : FETCH;
            end
          end
        end
        HALTED: begin
          if (irq_take) begin
            epc    <= pc_q;
            irq_en <= 1'b0;
            st     <= FETCH;
          end
        end
        default: st <= BOOT;
      endcase
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - table-driven bench for pc_sequencer with a behavioural PC register
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [14:0] pc_q = 15'h1234;
  logic [14:0] pc_d;
  logic        pc_re, pc_inc, imem_req, imem_ack, ir_load;
  logic        done, br_taken, halt, ret, irq, irq_ack;
  logic [14:0] br_target;
  logic [2:0]  state;

  int nchk = 0;
  int nfail = 0;

  pc_sequencer dut (
    .clk(clk), .rst(rst), .pc_q(pc_q), .pc_d(pc_d), .pc_re(pc_re), .pc_inc(pc_inc),
    .imem_req(imem_req), .imem_ack(imem_ack), .ir_load(ir_load), .done(done),
    .br_taken(br_taken), .br_target(br_target), .halt(halt), .ret(ret), .irq(irq),
    .irq_ack(irq_ack), .state(state)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (pc_re) pc_q <= pc_d;
    else if (pc_inc) pc_q <= pc_q + 15'd1;
  end

  localparam logic [2:0] BO = 3'd0, FE = 3'd1, EX = 3'd2, HA = 3'd3;
  // ctl = {rst, imem_ack, done, irq}
  localparam logic [3:0] C0 = 4'b0000, CRST = 4'b1000, CACK = 4'b0100, CDONE = 4'b0010,
                         CIRQ = 4'b0001, CRA = 4'b1100, CAI = 4'b0101;
  // br = {br_taken, halt, ret}
  localparam logic [2:0] B0 = 3'b000, BT = 3'b100, BH = 3'b010, BR = 3'b001;
  // strb = {pc_re, pc_inc, imem_req, ir_load, irq_ack}
  localparam logic [4:0] NONE = 5'b00000, LOAD = 5'b10000, INC = 5'b01000,
                         REQ = 5'b00100, FTCH = 5'b00110, IACK = 5'b10001;

  typedef struct {
    logic [3:0]  ctl;
    logic [2:0]  br;
    logic [14:0] tgt;
    logic [2:0]  st;
    logic [14:0] pc;
    logic [14:0] pd;
    logic [4:0]  strb;
  } vec_t;

  vec_t tbl[$];

  task automatic add(input logic [3:0] ctl, input logic [2:0] br, input logic [14:0] tgt,
                     input logic [2:0] st, input logic [14:0] pc, input logic [14:0] pd,
                     input logic [4:0] strb);
    vec_t v;
    v.ctl = ctl; v.br = br; v.tgt = tgt; v.st = st; v.pc = pc; v.pd = pd; v.strb = strb;
    tbl.push_back(v);
  endtask

  task automatic drive(input logic [3:0] ctl, input logic [2:0] br, input logic [14:0] tgt);
    {rst, imem_ack, done, irq} = ctl;
    {br_taken, halt, ret} = br;
    br_target = tgt;
  endtask

  task automatic chk(input string nm, input logic [2:0] st, input logic [14:0] pc,
                     input logic [14:0] pd, input logic [4:0] strb);
    logic [4:0] got;
    got = {pc_re, pc_inc, imem_req, ir_load, irq_ack};
    nchk++;
    if (state !== st || pc_q !== pc || pc_d !== pd || got !== strb) begin
      nfail++;
      $display("FAIL %s: got st=%0d pc=%h pd=%h strb=%b, want st=%0d pc=%h pd=%h strb=%b",
               nm, state, pc_q, pc_d, got, st, pc, pd, strb);
    end
  endtask

  task automatic step(input string nm, input logic [3:0] ctl, input logic [2:0] br,
                      input logic [14:0] tgt, input logic [2:0] st, input logic [14:0] pc,
                      input logic [14:0] pd, input logic [4:0] strb);
    @(negedge clk);
    drive(ctl, br, tgt);
    #1 chk(nm, st, pc, pd, strb);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(CRST, B0, 15'h0);

    // reset/boot, then sequential fetch with two wait states
    add(CRST,  B0, 15'h0,    BO, 15'h1234, 15'h0,    NONE);
    add(C0,    B0, 15'h0,    BO, 15'h1234, 15'h0,    LOAD);
    add(C0,    B0, 15'h0,    FE, 15'h0,    15'h0,    REQ);
    add(CDONE, B0, 15'h0,    FE, 15'h0,    15'h0,    REQ);
    add(CACK,  B0, 15'h0,    FE, 15'h0,    15'h0,    FTCH);
    add(C0,    B0, 15'h0,    EX, 15'h0,    15'h0,    NONE);
    add(CDONE, B0, 15'h0,    EX, 15'h0,    15'h0,    INC);
    add(CACK,  B0, 15'h0,    FE, 15'h1,    15'h0,    FTCH);
    add(CDONE, B0, 15'h0,    EX, 15'h1,    15'h0,    INC);
    add(CACK,  B0, 15'h0,    FE, 15'h2,    15'h0,    FTCH);
    // branches: to 5, then 5 -> 0123, then to 7
    add(CDONE, BT, 15'h5,    EX, 15'h2,    15'h5,    LOAD);
    add(CACK,  B0, 15'h0,    FE, 15'h5,    15'h0,    FTCH);
    add(CDONE, BT, 15'h0123, EX, 15'h5,    15'h0123, LOAD);
    add(C0,    B0, 15'h0,    FE, 15'h0123, 15'h0,    REQ);
    add(CACK,  B0, 15'h0,    FE, 15'h0123, 15'h0,    FTCH);
    add(CDONE, BT, 15'h7,    EX, 15'h0123, 15'h7,    LOAD);
    add(CACK,  B0, 15'h0,    FE, 15'h7,    15'h0,    FTCH);
    // irq pulse at pc 7, taken at done; irq in handler is not latched; ret returns to 8
    add(CIRQ,  B0, 15'h0,    EX, 15'h7,    15'h0,    NONE);
    add(CDONE, B0, 15'h0,    EX, 15'h7,    15'h7F00, IACK);
    add(CAI,   B0, 15'h0,    FE, 15'h7F00, 15'h0,    FTCH);
    add(CDONE, BR, 15'h0,    EX, 15'h7F00, 15'h8,    LOAD);
    add(CACK,  B0, 15'h0,    FE, 15'h8,    15'h0,    FTCH);
    add(CDONE, BT, 15'h9,    EX, 15'h8,    15'h9,    LOAD);
    add(CACK,  B0, 15'h0,    FE, 15'h9,    15'h0,    FTCH);
    // halt at 9, stays halted with ack/done ignored, wakes on irq with epc 10
    add(CDONE, BH, 15'h0,    EX, 15'h9,    15'h0,    INC);
    for (int i = 0; i < 10; i++)
      add((i % 2 == 1) ? CACK : CDONE, 3'b110, 15'h0055, HA, 15'd10, 15'h0, NONE);
    add(CIRQ,  B0, 15'h0,    HA, 15'd10,   15'h0,    NONE);
    add(C0,    B0, 15'h0,    HA, 15'd10,   15'h7F00, IACK);
    add(CACK,  B0, 15'h0,    FE, 15'h7F00, 15'h0,    FTCH);
    add(CDONE, BR, 15'h0,    EX, 15'h7F00, 15'd10,   LOAD);
    // ret wins over a pending irq; irq taken at the following done
    add(CACK,  B0, 15'h0,    FE, 15'd10,   15'h0,    FTCH);
    add(CIRQ,  B0, 15'h0,    EX, 15'd10,   15'h0,    NONE);
    add(CDONE, BR, 15'h0,    EX, 15'd10,   15'd10,   LOAD);
    add(CACK,  B0, 15'h0,    FE, 15'd10,   15'h0,    FTCH);
    add(CDONE, B0, 15'h0,    EX, 15'd10,   15'h7F00, IACK);
    add(CACK,  B0, 15'h0,    FE, 15'h7F00, 15'h0,    FTCH);
    add(CDONE, BR, 15'h0,    EX, 15'h7F00, 15'd11,   LOAD);
    // reset with imem_ack on the same edge; ack in BOOT ignored
    add(CRA,   B0, 15'h0,    FE, 15'd11,   15'h0,    NONE);
    add(CACK,  B0, 15'h0,    BO, 15'd11,   15'h0,    LOAD);
    add(C0,    B0, 15'h0,    FE, 15'h0,    15'h0,    REQ);
    add(CACK,  B0, 15'h0,    FE, 15'h0,    15'h0,    FTCH);
    // wrap at 7FFF: increment, then irq at 7FFF with halt discarded, epc 0
    add(CDONE, BT, 15'h7FFF, EX, 15'h0,    15'h7FFF, LOAD);
    add(CACK,  B0, 15'h0,    FE, 15'h7FFF, 15'h0,    FTCH);
    add(CDONE, B0, 15'h0,    EX, 15'h7FFF, 15'h0,    INC);
    add(CACK,  B0, 15'h0,    FE, 15'h0,    15'h0,    FTCH);
    add(CDONE, BT, 15'h7FFF, EX, 15'h0,    15'h7FFF, LOAD);
    add(CACK,  B0, 15'h0,    FE, 15'h7FFF, 15'h0,    FTCH);
    add(CIRQ,  B0, 15'h0,    EX, 15'h7FFF, 15'h0,    NONE);
    add(CDONE, BH, 15'h0,    EX, 15'h7FFF, 15'h7F00, IACK);
    add(CACK,  B0, 15'h0,    FE, 15'h7F00, 15'h0,    FTCH);
    add(CDONE, BR, 15'h0,    EX, 15'h7F00, 15'h0,    LOAD);
    add(C0,    B0, 15'h0,    FE, 15'h0,    15'h0,    REQ);

    // outputs are quiet during the very first reset cycle, before state is known
    #1;
    nchk++;
    if ({pc_re, pc_inc, imem_req, ir_load, irq_ack} !== 5'b0 || pc_d !== 15'h0) begin
      nfail++;
      $display("FAIL reset_quiet: got strb=%b pd=%h, want strb=00000 pd=0000",
               {pc_re, pc_inc, imem_req, ir_load, irq_ack}, pc_d);
    end

    foreach (tbl[i])
      step($sformatf("row%0d", i), tbl[i].ctl, tbl[i].br, tbl[i].tgt,
           tbl[i].st, tbl[i].pc, tbl[i].pd, tbl[i].strb);

    // long fetch wait, then reset mid-execute clears a pending irq
    for (int i = 0; i < 3; i++) step("fetch_wait", C0, B0, 15'h0, FE, 15'h0, 15'h0, REQ);
    step("fetch_ack",  CACK,  B0, 15'h0, FE, 15'h0, 15'h0, FTCH);
    step("exec_irq",   CIRQ,  B0, 15'h0, EX, 15'h0, 15'h0, NONE);
    step("exec_rst",   4'b1010, B0, 15'h0, EX, 15'h0, 15'h0, NONE);
    step("boot_again", C0,    B0, 15'h0, BO, 15'h0, 15'h0, LOAD);
    step("fetch_post", CACK,  B0, 15'h0, FE, 15'h0, 15'h0, FTCH);
    step("no_stale_irq", CDONE, B0, 15'h0, EX, 15'h0, 15'h0, INC);
    step("after_inc",  C0,    B0, 15'h0, FE, 15'h1, 15'h0, REQ);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nchk, nfail);
    $finish;
  end

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
- Instruction-sequencing controller that owns the program counter's load/increment strobes.
- Runs the fetch/execute loop against instruction memory and applies branch, halt, interrupt and return-from-interrupt decisions.
- Sits between the decode/execute unit and the PC register: drives the PC's in1/re/inc and reads back its out1.

Parameters:
- ADDR_W, 15, PC/address width (matches PC register).
- RESET_VEC, 15'h0000, first fetch address after reset.
- IRQ_VEC, 15'h7F00, interrupt handler entry address.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  synchronous, active-high reset.
- pc_q  in  ADDR_W  current PC value (PC out1).
- pc_d  out  ADDR_W  PC load value (to PC in1).
- pc_re  out  1  PC load strobe.
- pc_inc  out  1  PC increment strobe.
- imem_req  out  1  instruction fetch request, address = pc_q.
- imem_ack  in  1  fetch data valid.
- ir_load  out  1  latch fetched word into instruction register.
- done  in  1  execute unit: current instruction complete, branch fields valid.
- br_taken  in  1  branch taken (qualified by done).
- br_target  in  ADDR_W  branch destination.
- halt  in  1  halt instruction (qualified by done).
- ret  in  1  return-from-interrupt (qualified by done).
- irq  in  1  level interrupt request.
- irq_ack  out  1  one-cycle interrupt acceptance pulse.
- state  out  3  FSM state for debug.

Behaviour:
- Reset:
  - Any rising edge with rst=1: state=BOOT, epc=0, irq_en=1, irq_pend=0.
  - pc_re, pc_inc, imem_req, ir_load and irq_ack are all 0 while in BOOT, except the BOOT load below.
  - Reset mid-fetch or mid-execute aborts immediately. No outstanding request is honoured, and an imem_ack arriving in BOOT is ignored.
- Strobe outputs are combinational from state and inputs. PC updates at the next edge.
- pc_re and pc_inc are never both 1; pc_d=0 whenever pc_re=0.
- States: BOOT=0, FETCH=1, EXEC=2, HALTED=3.
- BOOT:
  - With rst=0: pc_d=RESET_VEC, pc_re=1, then FETCH.
  - Reset-to-first-imem_req latency is 1 cycle after rst deasserts.
- FETCH:
  - imem_req=1, held until imem_ack.
  - Cycle with imem_ack=1: ir_load=1, imem_req=1, then EXEC. Minimum fetch is 1 cycle.
- EXEC:
  - Wait for done; no strobes until then. On the done cycle exactly one PC action occurs, by priority:
  - 1) ret=1: pc_d=epc, pc_re=1, irq_en<=1, then FETCH.
  - 2) irq_pend=1 and irq_en=1:
    - epc <= next, where next = br_taken ? br_target : pc_q+1 (mod 2^ADDR_W).
    - pc_d=IRQ_VEC, pc_re=1, irq_ack=1, irq_en<=0, irq_pend<=0, then FETCH.
    - A halt asserted on the same done cycle is discarded.
  - 3) br_taken=1: pc_d=br_target, pc_re=1.
  - 4) Otherwise pc_inc=1.
  - For 3) and 4): next state is HALTED if halt=1, else FETCH.
- Interrupt pending:
  - irq_pend<=1 on any edge with irq=1 and irq_en=1 and no acceptance that cycle.
  - Cleared only by acceptance or reset.
  - irq while irq_en=0 is not latched; a level still high when irq_en returns to 1 is latched then.
  - ret together with irq_pend: ret wins; the interrupt is taken at the next done.
- HALTED:
  - No strobes, no fetch.
  - When irq_pend=1 and irq_en=1: epc<=pc_q, pc_d=IRQ_VEC, pc_re=1, irq_ack=1, irq_en<=0, then FETCH.
  - Otherwise remains in HALTED until rst.
- Wrap-around: pc_q=15'h7FFF with no branch gives pc_inc=1; epc computed as 0.
- done or imem_ack outside their owning state is ignored.

Test Plan:
- Reset/boot: rst=1 for 2 cycles, then 0.
  - Expect pc_re=1 with pc_d=0 in the first cycle.
  - Expect imem_req=1 the next cycle; all outputs 0 during reset.
- Sequential fetch: imem_ack after 2 wait cycles, then done=1 with br_taken=0.
  - Expect ir_load for 1 cycle, pc_inc=1 on the done cycle, and pc_q advancing 0→1→2 over 2 instructions.
- Branch: pc_q=5, done=1, br_taken=1, br_target=15'h0123.
  - Expect pc_re=1, pc_d=15'h0123, pc_inc=0, then a fetch at 15'h0123.
- Interrupt:
  - Pulse irq at pc_q=7 during EXEC, then done with br_taken=0: expect irq_ack=1, pc_d=15'h7F00, epc=8.
  - Then done with ret=1: expect pc_d=8, pc_re=1, irq_en=1.
- Halt/wake: done=1 with halt=1 at pc_q=9.
  - Expect pc_inc, then state=3 with no imem_req for 10 cycles.
  - Then irq=1: expect irq_ack, pc_d=15'h7F00, epc=10.
- Reset mid-fetch and wrap:
  - rst asserted during FETCH with imem_ack=1 at the same edge: expect BOOT, no ir_load afterwards, reload to 0.
  - pc_q=15'h7FFF with done=1 and no branch: expect pc_inc=1.
